// File: rtl/rmii_rx_deframer_pkg.sv
// Shared Ethernet/RMII constants, deframer state encoding and the sampler stage record.
// The receive deframer and its input sampler both import this package.
package rmii_rx_deframer_pkg;

  localparam int BYTE_LEN         = 8;
  localparam int ETH_PREAMBLE_LEN = 8;
  localparam int ETH_MAC_LEN      = 6;

  localparam logic [1:0] ETH_SFD_DIBIT      = 2'b11;
  localparam logic [1:0] ETH_PREAMBLE_DIBIT = 2'b01;

  typedef enum logic [1:0] {
    ST_DROP,
    ST_IDLE,
    ST_PREAMBLE,
    ST_BODY
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] dibit;
  } rmii_sample_t;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/rmii_rx_sampler.sv
// Two-stage {crs_dv, rxd} capture; exposes the live and staged valids and the stage2 dibit.
// The deframer looks two samples ahead of the dibit it is deciding on.
module rmii_rx_sampler
  import rmii_rx_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic       v0,
  output logic       v1,
  output logic       v2,
  output logic [1:0] dibit2
);

  rmii_sample_t stage1_d, stage1_q;
  rmii_sample_t stage2_d, stage2_q;

  always_comb begin
    stage1_d = '{valid: crs_dv, dibit: rxd};
    stage2_d = stage1_q;
  end

  // NOTE: registers use non-blocking assignments so both stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign v0     = crs_dv;
  assign v1     = stage1_q.valid;
  assign v2     = stage2_q.valid;
  assign dibit2 = stage2_q.dibit;

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, rides out CRS_DV toggling and emits the frame
// body as a contiguous dibit stream with done/err pulses aligned to the deciding dibit.
module rmii_rx_deframer
  import rmii_rx_deframer_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MAX_PREAMBLE_DIBITS = ETH_PREAMBLE_LEN * 4 - 1,
  parameter int MAX_FRAME_DIBITS    = 6088
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int PW = clog2(MAX_PREAMBLE_DIBITS + 1);
  localparam int BW = clog2(MAX_FRAME_DIBITS + 1);
  localparam int DW = clog2(BYTE_LEN / 2);

  localparam logic [PW-1:0] PCNT_MIN = PW'(MIN_PREAMBLE_DIBITS);
  localparam logic [PW-1:0] PCNT_MAX = PW'(MAX_PREAMBLE_DIBITS);
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_FRAME_DIBITS);

  logic       v0, v1, v2;
  logic [1:0] dibit2;
  logic       eoc;
  logic       body_valid;

  state_e        state_d, state_q;
  logic [PW-1:0] pcnt_d, pcnt_q;
  logic [BW-1:0] bcnt_d, bcnt_q;
  logic          busy_d, busy_q;

  rmii_rx_sampler u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .crs_dv (crs_dv),
    .rxd    (rxd),
    .v0     (v0),
    .v1     (v1),
    .v2     (v2),
    .dibit2 (dibit2)
  );

  // Carrier is over once neither the next staged sample nor the live input is valid.
  assign eoc        = !v1 && !v0;
  assign body_valid = v2 || v1;

  // NOTE: every combinational output gets a default up front so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    outclk  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      ST_DROP: begin
        if (eoc) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (v2) begin
          if (dibit2 == ETH_PREAMBLE_DIBIT) begin
            pcnt_d  = PW'(1);
            state_d = ST_PREAMBLE;
          end else if (dibit2 != 2'b00) begin
            err     = 1'b1;
            state_d = ST_DROP;
          end
        end
      end

      ST_PREAMBLE: begin
        if (v2 && dibit2 == ETH_PREAMBLE_DIBIT) begin
          if (pcnt_q == PCNT_MAX) begin
            err     = 1'b1;
            state_d = ST_DROP;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
            if (eoc) state_d = ST_IDLE;
          end
        end else if (v2 && dibit2 == ETH_SFD_DIBIT && pcnt_q >= PCNT_MIN) begin
          bcnt_d  = '0;
          state_d = ST_BODY;
        end else if (v2) begin
          err     = 1'b1;
          state_d = ST_DROP;
        end else if (eoc) begin
          state_d = ST_IDLE;
        end
      end

      ST_BODY: begin
        if (body_valid) begin
          // Oversize wins over last-dibit detection; the missing done lets eth_rx see a gap.
          if (bcnt_q == BCNT_MAX) begin
            err     = 1'b1;
            state_d = ST_DROP;
          end else begin
            outclk = 1'b1;
            bcnt_d = bcnt_q + BW'(1);
            if (eoc) begin
              done    = 1'b1;
              err     = (bcnt_d[DW-1:0] != '0);
              state_d = ST_IDLE;
            end
          end
        end else if (eoc) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_DROP;
    endcase

    busy_d = (state_d == ST_PREAMBLE) || (state_d == ST_BODY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DROP;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = dibit2;
  assign busy = busy_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer: nominal frame, carrier toggle, preamble errors,
// dribble, oversize (second instance with a 16-dibit limit) and mid-frame reset.
module tb_rmii_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       crs_dv;
  logic [1:0] rxd;

  logic       outclk, done, err, busy;
  logic [1:0] out;
  logic       s_outclk, s_done, s_err, s_busy;
  logic [1:0] s_out;

  int vectors     = 0;
  int miscompares = 0;

  rmii_rx_deframer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .crs_dv (crs_dv),
    .rxd    (rxd),
    .outclk (outclk),
    .out    (out),
    .done   (done),
    .err    (err),
    .busy   (busy)
  );

  rmii_rx_deframer #(.MAX_FRAME_DIBITS(16)) dut_small (
    .clk    (clk),
    .rst_n  (rst_n),
    .crs_dv (crs_dv),
    .rxd    (rxd),
    .outclk (s_outclk),
    .out    (s_out),
    .done   (s_done),
    .err    (s_err),
    .busy   (s_busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter and output monitors, sampled on the falling edge.
  int         cyc = 0;
  logic [1:0] rx_q[$];
  int         rises = 0, rise_cyc = 0;
  int         done_cnt = 0, done_pos = 0;
  int         err_cnt = 0, err_pos = 0, err_cyc = 0;
  logic       err_with_oc = 1'b0;
  logic       prev_oc = 1'b0;
  int         s_oc = 0, s_done_cnt = 0, s_err_cnt = 0, s_err_cyc = 0, s_last_oc_cyc = 0;
  logic       s_err_oc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (outclk === 1'b1) begin
      rx_q.push_back(out);
      if (!prev_oc) begin
        rises    <= rises + 1;
        rise_cyc <= cyc;
      end
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_pos <= rx_q.size();
    end
    if (err === 1'b1) begin
      err_cnt     <= err_cnt + 1;
      err_pos     <= rx_q.size();
      err_cyc     <= cyc;
      err_with_oc <= outclk;
    end
    prev_oc <= (outclk === 1'b1);
    if (s_outclk === 1'b1) begin
      s_oc          <= s_oc + 1;
      s_last_oc_cyc <= cyc;
    end
    if (s_done === 1'b1) s_done_cnt <= s_done_cnt + 1;
    if (s_err === 1'b1) begin
      s_err_cnt <= s_err_cnt + 1;
      s_err_cyc <= cyc;
      s_err_oc  <= s_outclk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Body byte k is k*7+3, sent LSB dibit first.
  function automatic logic [1:0] body_dibit(input int k);
    logic [7:0] b;
    b = 8'((k / 4) * 7 + 3);
    return b[2 * (k % 4) +: 2];
  endfunction

  function automatic logic [1:0] q_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 2'bxx;
  endfunction

  task automatic drv(input logic cv, input logic [1:0] d);
    crs_dv = cv;
    rxd    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 2'b00);
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) drv(1'b1, 2'b01);
  endtask

  task automatic send_body(input int from, input int to);
    for (int k = from; k < to; k++) drv(1'b1, body_dibit(k));
  endtask

  int base, r0, d0, e0, so0, sd0, se0, c0;

  task automatic snap();
    base = rx_q.size();
    r0   = rises;
    d0   = done_cnt;
    e0   = err_cnt;
    so0  = s_oc;
    sd0  = s_done_cnt;
    se0  = s_err_cnt;
  endtask

  task automatic check_body(input string tag, input int n);
    int mism;
    mism = 0;
    for (int k = 0; k < n; k++)
      if (q_at(base + k) !== body_dibit(k)) mism++;
    chk({tag, "_count"}, 32'(rx_q.size() - base), 32'(n));
    chk({tag, "_data"}, 32'(mism), 0);
    chk({tag, "_contig"}, 32'(rises - r0), 1);
  endtask

  initial begin
    rst_n  = 1'b1;
    crs_dv = 1'b0;
    rxd    = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({outclk, out, done, err, busy}), 0);
    chk("reset_small", 32'({s_outclk, s_out, s_done, s_err, s_busy}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Nominal: 31 preamble dibits, SFD, 64 bytes.
    snap();
    send_pre(31);
    drv(1'b1, 2'b11);
    c0 = cyc;
    send_body(0, 128);
    chk("t1_busy_mid", 32'(busy), 1);
    send_body(128, 256);
    idle(3);
    check_body("t1", 256);
    chk("t1_first", 32'(q_at(base)), 32'(2'b11));
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_done_pos", 32'(done_pos - base), 256);
    chk("t1_err", 32'(err_cnt - e0), 0);
    chk("t1_latency", 32'(rise_cyc - c0), 2);
    chk("t1_busy_end", 32'(busy), 0);

    // Carrier toggle on the last four dibits, with the minimum accepted preamble length.
    // Each deasserted sample is followed by an asserted one, so every dibit stays valid.
    snap();
    send_pre(8);
    drv(1'b1, 2'b11);
    send_body(0, 12);
    drv(1'b0, body_dibit(12));
    drv(1'b1, body_dibit(13));
    drv(1'b0, body_dibit(14));
    drv(1'b1, body_dibit(15));
    idle(3);
    check_body("t2", 16);
    chk("t2_done_pos", 32'(done_pos - base), 16);
    chk("t2_err", 32'(err_cnt - e0), 0);
    chk("t2_small_done_at_limit", 32'(s_done_cnt - sd0), 1);
    chk("t2_small_err_at_limit", 32'(s_err_cnt - se0), 0);

    // Bad preamble dibit, then a well-formed frame while the carrier is still up.
    snap();
    send_pre(10);
    c0 = cyc;
    drv(1'b1, 2'b10);
    send_pre(8);
    drv(1'b1, 2'b11);
    send_body(0, 8);
    chk("t3_err", 32'(err_cnt - e0), 1);
    chk("t3_err_latency", 32'(err_cyc - c0), 2);
    chk("t3_no_outclk", 32'(rx_q.size() - base), 0);
    chk("t3_busy_drop", 32'(busy), 0);
    idle(2);
    snap();
    send_pre(8);
    drv(1'b1, 2'b11);
    send_body(0, 8);
    idle(3);
    check_body("t3_fresh", 8);
    chk("t3_fresh_done", 32'(done_cnt - d0), 1);
    chk("t3_fresh_err", 32'(err_cnt - e0), 0);

    // Short preambles: 4 and MIN-1 dibits before the SFD.
    snap();
    send_pre(4);
    drv(1'b1, 2'b11);
    send_body(0, 6);
    idle(3);
    send_pre(7);
    drv(1'b1, 2'b11);
    send_body(0, 6);
    idle(3);
    chk("t4_short_err", 32'(err_cnt - e0), 2);
    chk("t4_short_no_outclk", 32'(rx_q.size() - base), 0);

    // Preamble one dibit longer than the maximum.
    snap();
    send_pre(31);
    c0 = cyc;
    drv(1'b1, 2'b01);
    send_body(0, 4);
    idle(3);
    chk("t4_long_err", 32'(err_cnt - e0), 1);
    chk("t4_long_err_latency", 32'(err_cyc - c0), 2);
    chk("t4_long_no_outclk", 32'(rx_q.size() - base), 0);

    // Dribble: 258 dibits is not a whole number of bytes.
    snap();
    send_pre(8);
    drv(1'b1, 2'b11);
    send_body(0, 258);
    idle(3);
    check_body("t4_dribble", 258);
    chk("t4_dribble_done", 32'(done_cnt - d0), 1);
    chk("t4_dribble_done_pos", 32'(done_pos - base), 258);
    chk("t4_dribble_err", 32'(err_cnt - e0), 1);
    chk("t4_dribble_err_pos", 32'(err_pos - base), 258);
    chk("t4_dribble_err_with_outclk", 32'(err_with_oc), 1);

    // Oversize: 20 body dibits against the 16-dibit instance.
    snap();
    send_pre(8);
    drv(1'b1, 2'b11);
    send_body(0, 20);
    idle(3);
    chk("t5_small_outclk", 32'(s_oc - so0), 16);
    chk("t5_small_err", 32'(s_err_cnt - se0), 1);
    chk("t5_small_done", 32'(s_done_cnt - sd0), 0);
    chk("t5_small_err_next_cycle", 32'(s_err_cyc - s_last_oc_cyc), 1);
    chk("t5_small_err_no_outclk", 32'(s_err_oc), 0);
    chk("t5_small_busy", 32'(s_busy), 0);
    check_body("t5_big", 20);
    chk("t5_big_done", 32'(done_cnt - d0), 1);
    chk("t5_big_err", 32'(err_cnt - e0), 0);

    // Reset in the middle of a body, released with the carrier still up.
    send_pre(31);
    drv(1'b1, 2'b11);
    send_body(0, 10);
    chk("t6_pre_reset_outclk", 32'(outclk), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 32'({outclk, out, done, err, busy}), 0);
    snap();
    send_body(10, 13);
    rst_n = 1'b1;
    send_body(13, 23);
    chk("t6_drop_no_outclk", 32'(rx_q.size() - base), 0);
    chk("t6_drop_no_err", 32'(err_cnt - e0), 0);
    chk("t6_drop_busy", 32'(busy), 0);
    idle(2);
    snap();
    send_pre(31);
    drv(1'b1, 2'b11);
    send_body(0, 32);
    idle(3);
    check_body("t6_after", 32);
    chk("t6_after_done", 32'(done_cnt - d0), 1);
    chk("t6_after_err", 32'(err_cnt - e0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
